seg_pattern_decoder: RTL
========================

// Module: seg_pattern_decoder
// PURPOSE
//  Reverse path of the 7-segment encoder: samples a multiplexed 7-segment bus (segments + digit
//  select), waits for each pattern to be stable, decodes it back to a 4-bit digit value and holds
//  it per digit. Sits on the verification/readback side of the traffic-light/gate display so that
//  firmware and self-check logic can read what is actually shown on the display.
// PARAMETERS
//  DIGITS         2  number of multiplexed digits (1..8)
//  STABLE_CYCLES  4  consecutive identical samples required before commit (2..255)
// PORTS
//  clk        in   1          system clock; all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  seg_in     in   7          segments {a,b,c,d,e,f,g}, bit6=a, active-high
//  dig_sel    in   DIGITS     digit enable, active-high; exactly one bit set = valid digit slot
//  value_out  out  4*DIGITS   decoded value, digit i at [4i+3:4i]
//  valid_out  out  DIGITS     digit i currently shows a decodable symbol
//  upd_pulse  out  1          1-cycle pulse on each valid or blank commit
//  err_pulse  out  1          1-cycle pulse on commit of an undecodable pattern
//  err_count  out  8          saturating error counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: value_out=0, valid_out=0, upd_pulse=0, err_pulse=0, err_count=0; sample reg,
//    stability counter and commit-done flag cleared. Reset wins over any same-cycle commit.
//  - Stage 1: {dig_sel,seg_in} registered every cycle (sample S).
//  - Stability counter C (width clog2(STABLE_CYCLES+1)): S != previous S -> C=1, done=0;
//    S == previous S -> C=C+1, saturating at STABLE_CYCLES.
//  - Commit when C reaches STABLE_CYCLES and done=0; set done=1 (exactly one commit per stable
//    window; re-commit only after S changes). Commit effects registered, visible next cycle.
//  - Latency: inputs held from edge k -> outputs updated at edge k+STABLE_CYCLES+1.
//  - dig_sel zero or multi-hot at commit: no update, no pulse (blanking interval, not an error).
//  - Decode at commit (digit d = index of set dig_sel bit):
//      1111110->0 0110000->1 1101101->2 1111001->3 0110011->4 1011011->5 1011111->6
//      1110000->7 1111111->8 1111011->9 : value[d]=code, valid[d]=1, upd_pulse
//      0000001 (dash)  : value[d]=4'hE, valid[d]=1, upd_pulse
//      0000000 (blank) : valid[d]=0, value[d] unchanged, upd_pulse
//      any other       : valid[d]=0, value[d] unchanged, err_pulse
//  - Other digits' value/valid never change on a commit to digit d.
//  - Pattern changes before C reaches STABLE_CYCLES: window restarts, nothing committed.
//  - Pulses are single-cycle, never both high in the same cycle.
// CONFIGURATION
//  SEG_DECODER_ERR_CNT_EN defined: err_count increments on every err_pulse, saturates at 255,
//    cleared only by rst.
//  Not defined: no counter logic; err_count tied to 8'd0.
// STRUCTURE
//  - seg_pkg: SEG_PAT_0..SEG_PAT_9, SEG_PAT_DASH, SEG_PAT_BLANK (7-bit, a..g, active-high),
//    VAL_DASH=4'hE; shared with the 7-segment encoder so both directions use one table.
//  - Sub-module seg_pattern_lookup (combinational): 7-bit pattern -> {code[3:0], is_sym,
//    is_blank}. Top holds sample reg, stability counter, per-digit registers, pulses, counter.
// TESTING
//  1 Reset: assert rst 2 cycles mid-count -> all outputs 0, no pulse on release.
//  2 dig_sel=01, seg=1011011 held 6 cycles -> value[3:0]=5, valid=01, one upd_pulse at edge 5.
//  3 dig_sel=10, seg=1111111 held 3 cycles then 1111110 held 4 -> only digit1=0 committed,
//    no commit for 8; digit0 unchanged.
//  4 dig_sel=01, seg=1010101 held 4 -> err_pulse once, valid[0]=0, value[0] kept; with
//    SEG_DECODER_ERR_CNT_EN 300 such errors -> err_count=255, without -> 0.
//  5 dig_sel=11 or 00 with seg=0110000 held 10 cycles -> no pulses, outputs unchanged.
//  6 Alternate digit0=3/digit1=0000001 every 8 cycles -> value=8'hE3, valid=11, one upd_pulse
//    per window; then seg=0000000 on digit1 -> valid=01, digit1 value stays E.

Source files
------------

// File: rtl/seg_pattern_decoder_pkg.sv
// Shared 7-segment pattern table (segments a..g, bit6 = a, active-high).
// The encoder and the readback decoder both pull their patterns from here,
// so the two directions can never disagree about what a digit looks like.
package seg_pattern_decoder_pkg;

   localparam logic [6:0] SEG_PAT_0     = 7'b1111110;
   localparam logic [6:0] SEG_PAT_1     = 7'b0110000;
   localparam logic [6:0] SEG_PAT_2     = 7'b1101101;
   localparam logic [6:0] SEG_PAT_3     = 7'b1111001;
   localparam logic [6:0] SEG_PAT_4     = 7'b0110011;
   localparam logic [6:0] SEG_PAT_5     = 7'b1011011;
   localparam logic [6:0] SEG_PAT_6     = 7'b1011111;
   localparam logic [6:0] SEG_PAT_7     = 7'b1110000;
   localparam logic [6:0] SEG_PAT_8     = 7'b1111111;
   localparam logic [6:0] SEG_PAT_9     = 7'b1111011;
   localparam logic [6:0] SEG_PAT_DASH  = 7'b0000001;
   localparam logic [6:0] SEG_PAT_BLANK = 7'b0000000;

   // Value reported for the dash symbol
   localparam logic [3:0] VAL_DASH = 4'hE;

   // What a committed pattern means for the digit it lands on
   typedef enum logic [1:0] {
      CLASS_SYMBOL,
      CLASS_BLANK,
      CLASS_ERROR
   } segClass_t;

   // Collapse the lookup flags into a single classification
   function automatic segClass_t segClassify(input logic isSym, input logic isBlank);
      if (isSym) begin
         return CLASS_SYMBOL;
      end else if (isBlank) begin
         return CLASS_BLANK;
      end
      return CLASS_ERROR;
   endfunction

endpackage

// File: rtl/seg_pattern_decoder_lookup.sv
// Combinational reverse lookup: 7-bit segment pattern -> digit code plus
// flags telling whether the pattern is a known symbol or a blank display.
module seg_pattern_decoder_lookup
   import seg_pattern_decoder_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] code,
   output logic       isSym,
   output logic       isBlank
);

   // Map every legal pattern back to its value; anything else is neither a
   // symbol nor a blank, which the top treats as an undecodable pattern.
   always_comb begin
      code    = 4'd0;
      isSym   = 1'b1;
      isBlank = 1'b0;
      case (pattern)
         SEG_PAT_0:     code = 4'd0;
         SEG_PAT_1:     code = 4'd1;
         SEG_PAT_2:     code = 4'd2;
         SEG_PAT_3:     code = 4'd3;
         SEG_PAT_4:     code = 4'd4;
         SEG_PAT_5:     code = 4'd5;
         SEG_PAT_6:     code = 4'd6;
         SEG_PAT_7:     code = 4'd7;
         SEG_PAT_8:     code = 4'd8;
         SEG_PAT_9:     code = 4'd9;
         SEG_PAT_DASH:  code = VAL_DASH;
         SEG_PAT_BLANK: begin
            isSym   = 1'b0;
            isBlank = 1'b1;
         end
         default:       isSym = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Readback decoder for a multiplexed 7-segment bus. Samples {dig_sel, seg_in}
// every cycle, waits until the sample has been identical for STABLE_CYCLES
// consecutive cycles, then commits the decoded value to the selected digit
// exactly once per stable window.
// Optional feature macro: SEG_DECODER_ERR_CNT_EN enables the saturating
// error counter on err_count; without it err_count is tied to zero.
module seg_pattern_decoder
   import seg_pattern_decoder_pkg::*;
#(
   parameter int DIGITS        = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     dig_sel,
   output logic [4*DIGITS-1:0]   value_out,
   output logic [DIGITS-1:0]     valid_out,
   output logic                  upd_pulse,
   output logic                  err_pulse,
   output logic [7:0]            err_count
);

   localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam int SAMPLE_W = DIGITS + 7;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [SAMPLE_W-1:0] sampleReg;
   logic [SAMPLE_W-1:0] prevSample;
   logic [CNT_W-1:0]    stableCnt;
   logic                commitDone;

   logic [DIGITS-1:0]   commitSel;
   logic [6:0]          commitSeg;
   logic                commitNow;
   logic                slotValid;
   logic [3:0]          lookupCode;
   logic                lookupSym;
   logic                lookupBlank;
   segClass_t           commitClass;

   // Once the counter has saturated, prevSample holds the pattern that was
   // stable for the whole window, while sampleReg may already hold the next
   // one, so the commit always decodes prevSample.
   assign commitSel   = prevSample[SAMPLE_W-1:7];
   assign commitSeg   = prevSample[6:0];
   assign commitNow   = (stableCnt == CNT_MAX) && !commitDone;
   assign slotValid   = $onehot(commitSel);
   assign commitClass = segClassify(lookupSym, lookupBlank);

   seg_pattern_decoder_lookup lookup (
      .pattern (commitSeg),
      .code    (lookupCode),
      .isSym   (lookupSym),
      .isBlank (lookupBlank)
   );

   // Register the raw bus and measure how long it has stayed unchanged;
   // any change restarts the window and re-arms the one-shot commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sampleReg  <= '0;
         prevSample <= '0;
         stableCnt  <= '0;
         commitDone <= 1'b0;
      end else begin
         sampleReg  <= {dig_sel, seg_in};
         prevSample <= sampleReg;
         if (sampleReg != prevSample) begin
            stableCnt  <= CNT_W'(1);
            commitDone <= 1'b0;
         end else begin
            if (stableCnt != CNT_MAX) begin
               stableCnt <= stableCnt + 1'b1;
            end
            if (commitNow) begin
               commitDone <= 1'b1;
            end
         end
      end
   end

   // Apply a commit to the one selected digit and raise the matching pulse;
   // zero or multiple selects are a blanking interval and change nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_out <= '0;
         valid_out <= '0;
         upd_pulse <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         upd_pulse <= 1'b0;
         err_pulse <= 1'b0;
         if (commitNow && slotValid) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (commitSel[i]) begin
                  if (commitClass == CLASS_SYMBOL) begin
                     value_out[4*i +: 4] <= lookupCode;
                     valid_out[i]        <= 1'b1;
                  end else begin
                     valid_out[i]        <= 1'b0;
                  end
               end
            end
            if (commitClass == CLASS_ERROR) begin
               err_pulse <= 1'b1;
            end else begin
               upd_pulse <= 1'b1;
            end
         end
      end
   end

`ifdef SEG_DECODER_ERR_CNT_EN
   logic errCommit;

   assign errCommit = commitNow && slotValid && (commitClass == CLASS_ERROR);

   // Count undecodable commits, sticking at 255 until the next reset
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= 8'd0;
      end else if (errCommit && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_count = 8'd0;
`endif

endmodule
